vector_register_file: RTL and testbench

//  Parametrised multi-lane register file for the decode stage of the vector ASIP. Next generation of the scalar register file.

---
 rtl/vrf_pkg.sv | 18 +
 rtl/vrf_row.sv | 33 +++
 rtl/vector_register_file.sv | 114 +++++++++++
 tb/tb_vector_register_file.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vrf_pkg.sv
// ----------------------------------------------------------------------------
// vrf_pkg: shared defaults and lane helper for the vector register file. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package vrf_pkg;

    localparam int VRF_LANES   = 4;
    localparam int VRF_LANE_W  = 8;
    localparam int VRF_REG_QTY = 8;

    function automatic int lane_slice(input int lane, input int lane_w);
        return lane * lane_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vrf_row.sv
// ----------------------------------------------------------------------------
// vrf_row: one vector register with per-lane write enables and async clear. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vrf_row
    import vrf_pkg::*;
#(
    parameter int LANES  = VRF_LANES,
    parameter int LANE_W = VRF_LANE_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [LANES-1:0]        lane_we,
    input  logic [LANES*LANE_W-1:0] d,
    output logic [LANES*LANE_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (lane_we[l]) begin
                    q[lane_slice(l, LANE_W) +: LANE_W] <= d[lane_slice(l, LANE_W) +: LANE_W];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/vector_register_file.sv
// ----------------------------------------------------------------------------
// vector_register_file: multi-lane register file with per-lane bypass and RAW scoreboard. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vector_register_file
    import vrf_pkg::*;
#(
    parameter int LANES    = VRF_LANES,
    parameter int LANE_W   = VRF_LANE_W,
    parameter int REG_QTY  = VRF_REG_QTY,
    parameter int SEL_BITS = $clog2(REG_QTY),
    parameter int ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wrEn,
    input  logic [SEL_BITS-1:0]     wrSel,
    input  logic [LANES-1:0]        wrMask,
    input  logic [LANES*LANE_W-1:0] dataIn,
    input  logic [SEL_BITS-1:0]     rSel1,
    input  logic [SEL_BITS-1:0]     rSel2,
    output logic [LANES*LANE_W-1:0] reg1Out,
    output logic [LANES*LANE_W-1:0] reg2Out,
    input  logic                    claimEn,
    input  logic [SEL_BITS-1:0]     claimSel,
    input  logic                    flush,
    output logic                    busy1,
    output logic                    busy2,
    output logic [REG_QTY-1:0]      pendingVec
);

    localparam int W = LANES * LANE_W;

    logic [W-1:0]        row_q [REG_QTY];
    logic [REG_QTY-1:0]  pending;
    logic [REG_QTY-1:0]  pending_nxt;
    logic                hit1;
    logic                hit2;

    function automatic logic [W-1:0] merge_lanes(
        input logic [W-1:0]     stored,
        input logic [W-1:0]     fresh,
        input logic [LANES-1:0] take
    );
        merge_lanes = stored;
        for (int l = 0; l < LANES; l++) begin
            if (take[l]) begin
                merge_lanes[lane_slice(l, LANE_W) +: LANE_W] = fresh[lane_slice(l, LANE_W) +: LANE_W];
            end
        end
    endfunction

    for (genvar r = 0; r < REG_QTY; r++) begin : g_row
        if (ZERO_REG != 0 && r == 0) begin : g_zero
            assign row_q[r] = '0;
        end else begin : g_flop
            logic row_we;
            assign row_we = wrEn && (wrSel == SEL_BITS'(r));

            vrf_row #(
                .LANES  (LANES),
                .LANE_W (LANE_W)
            ) u_row (
                .clk     (clk),
                .rst_n   (reset),
                .lane_we (wrMask & {LANES{row_we}}),
                .d       (dataIn),
                .q       (row_q[r])
            );
        end
    end

    // Bypass is gated by reset so outputs read zero the moment reset asserts.
    assign hit1 = reset && wrEn && (wrSel == rSel1) && !((ZERO_REG != 0) && (rSel1 == '0));
    assign hit2 = reset && wrEn && (wrSel == rSel2) && !((ZERO_REG != 0) && (rSel2 == '0));

    assign reg1Out = merge_lanes(row_q[rSel1], dataIn, wrMask & {LANES{hit1}});
    assign reg2Out = merge_lanes(row_q[rSel2], dataIn, wrMask & {LANES{hit2}});

    // A claim beats a same-cycle writeback: the claim is the newer producer.
    always_comb begin
        pending_nxt = pending;
        if (flush) begin
            pending_nxt = '0;
        end else begin
            for (int r = 0; r < REG_QTY; r++) begin
                if (claimEn && (claimSel == SEL_BITS'(r))) begin
                    pending_nxt[r] = 1'b1;
                end else if (wrEn && (wrSel == SEL_BITS'(r))) begin
                    pending_nxt[r] = 1'b0;
                end
            end
        end
        if (ZERO_REG != 0) begin
            pending_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    assign busy1      = pending[rSel1];
    assign busy2      = pending[rSel2];
    assign pendingVec = pending;

endmodule

`default_nettype wire

// File: tb/tb_vector_register_file.sv
// ----------------------------------------------------------------------------
// tb_vector_register_file: directed and random checks against an array-level model. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_vector_register_file;

    localparam int L  = 4;
    localparam int LW = 8;
    localparam int N  = 8;
    localparam int SB = 3;
    localparam int W  = L * LW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wrEn = 1'b0;
    logic [SB-1:0] wrSel = '0;
    logic [L-1:0]  wrMask = '0;
    logic [W-1:0]  dataIn = '0;
    logic [SB-1:0] rSel1 = '0;
    logic [SB-1:0] rSel2 = '0;
    logic          claimEn = 1'b0;
    logic [SB-1:0] claimSel = '0;
    logic          flush = 1'b0;

    // index 1: ZERO_REG=1 instance, index 0: ZERO_REG=0 instance
    logic [W-1:0]  o1 [2];
    logic [W-1:0]  o2 [2];
    logic          b1 [2];
    logic          b2 [2];
    logic [N-1:0]  pv [2];

    int n_tests = 0;
    int n_fail  = 0;

    logic [LW-1:0] mem  [2][N][L];
    bit            pend [2][N];

    always #5 clk = ~clk;

    vector_register_file #(.LANES(L), .LANE_W(LW), .REG_QTY(N), .ZERO_REG(1)) dut (
        .clk(clk), .reset(reset), .wrEn(wrEn), .wrSel(wrSel), .wrMask(wrMask), .dataIn(dataIn),
        .rSel1(rSel1), .rSel2(rSel2), .reg1Out(o1[1]), .reg2Out(o2[1]),
        .claimEn(claimEn), .claimSel(claimSel), .flush(flush),
        .busy1(b1[1]), .busy2(b2[1]), .pendingVec(pv[1])
    );

    vector_register_file #(.LANES(L), .LANE_W(LW), .REG_QTY(N), .ZERO_REG(0)) dut_nz (
        .clk(clk), .reset(reset), .wrEn(wrEn), .wrSel(wrSel), .wrMask(wrMask), .dataIn(dataIn),
        .rSel1(rSel1), .rSel2(rSel2), .reg1Out(o1[0]), .reg2Out(o2[0]),
        .claimEn(claimEn), .claimSel(claimSel), .flush(flush),
        .busy1(b1[0]), .busy2(b2[0]), .pendingVec(pv[0])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] m_read(input int z, input logic [SB-1:0] sel);
        logic [W-1:0] v;
        if (!reset || (z == 1 && sel == 0)) return '0;
        for (int l = 0; l < L; l++) begin
            v[l*LW +: LW] = (wrEn && wrSel == sel && wrMask[l]) ? dataIn[l*LW +: LW] : mem[z][sel][l];
        end
        return v;
    endfunction

    function automatic logic [N-1:0] m_pvec(input int z);
        logic [N-1:0] v;
        for (int r = 0; r < N; r++) v[r] = pend[z][r];
        return v;
    endfunction

    task automatic m_reset();
        for (int z = 0; z < 2; z++)
            for (int r = 0; r < N; r++) begin
                pend[z][r] = 1'b0;
                for (int l = 0; l < L; l++) mem[z][r][l] = '0;
            end
    endtask

    task automatic m_update();
        if (!reset) return;
        for (int z = 0; z < 2; z++) begin
            if (wrEn && !(z == 1 && wrSel == 0))
                for (int l = 0; l < L; l++)
                    if (wrMask[l]) mem[z][wrSel][l] = dataIn[l*LW +: LW];
            if (flush) begin
                for (int r = 0; r < N; r++) pend[z][r] = 1'b0;
            end else begin
                if (wrEn)    pend[z][wrSel]    = 1'b0;
                if (claimEn) pend[z][claimSel] = 1'b1;
            end
            if (z == 1) pend[z][0] = 1'b0;
        end
    endtask

    task automatic compare_all();
        for (int z = 0; z < 2; z++) begin
            check($sformatf("rd1_z%0d", z),  o1[z], m_read(z, rSel1));
            check($sformatf("rd2_z%0d", z),  o2[z], m_read(z, rSel2));
            check($sformatf("busy1_z%0d", z), b1[z], pend[z][rSel1]);
            check($sformatf("busy2_z%0d", z), b2[z], pend[z][rSel2]);
            check($sformatf("pvec_z%0d", z), pv[z], m_pvec(z));
        end
    endtask

    task automatic settle();
        @(negedge clk);
        compare_all();
    endtask

    task automatic tick();
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    task automatic idle();
        wrEn = 0; wrSel = '0; wrMask = '0; dataIn = '0;
        claimEn = 0; claimSel = '0; flush = 0;
    endtask

    task automatic write(input logic [SB-1:0] s, input logic [L-1:0] m, input logic [W-1:0] d);
        wrEn = 1; wrSel = s; wrMask = m; dataIn = d;
    endtask

    task automatic reset_pulse();
        #1 reset = 0;
        m_reset();
        #1 compare_all();
        #1 reset = 1;
    endtask

    initial begin
        m_reset();
        idle();
        #3;
        check("rst_rd1", o1[1], 0);
        check("rst_pvec", pv[1], 0);
        @(negedge clk);
        reset = 1;
        tick();

        // fill every register with A5, then reset asynchronously mid-cycle
        for (int r = 0; r < N; r++) begin
            write(SB'(r), 4'hF, 32'hA5A5A5A5);
            claimEn = 1; claimSel = SB'((r + 1) % N);
            step();
        end
        idle(); rSel1 = 1; rSel2 = 2;
        settle();
        check("fill_rd1", o1[1], 32'hA5A5A5A5);
        #1 reset = 0;
        m_reset();
        #1;
        check("async_rst_rd1", o1[1], 0);
        check("async_rst_rd2", o2[0], 0);
        check("async_rst_pvec", pv[0], 0);
        #1 reset = 1;
        tick();
        for (int r = 1; r < N; r++) begin
            rSel1 = SB'(r);
            settle();
            check("post_rst_rd", o1[1], 0);
            tick();
        end

        // masked write over all-ones
        write(3, 4'hF, 32'hFFFFFFFF); step();
        write(3, 4'b0101, 32'h44332211); step();
        idle(); rSel1 = 3;
        settle();
        check("masked_wr", o1[1], 32'hFF33FF11);
        tick();

        // same-cycle bypass, full and partial
        write(5, 4'hF, 32'hDEADBEEF); rSel1 = 5;
        settle();
        check("bypass_full", o1[1], 32'hDEADBEEF);
        tick();
        write(5, 4'b0011, 32'h11223344);
        settle();
        check("bypass_part", o1[1], 32'hDEAD3344);
        tick();

        // zero register
        write(0, 4'hF, 32'h12345678); claimEn = 1; claimSel = 0; rSel1 = 0;
        settle();
        check("zero_rd_bypass", o1[1], 0);
        check("nz_rd_bypass", o1[0], 32'h12345678);
        tick();
        idle();
        settle();
        check("zero_rd", o1[1], 0);
        check("zero_busy", b1[1], 0);
        check("zero_pend0", pv[1][0], 0);
        check("nz_rd", o1[0], 32'h12345678);
        check("nz_busy", b1[0], 1);
        tick();

        // scoreboard
        claimEn = 1; claimSel = 2; rSel1 = 2; step();
        idle();
        settle(); check("claim_busy", b1[1], 1); tick();
        write(2, 4'hF, 32'h0BADF00D); step();
        idle();
        settle(); check("wb_clears", b1[1], 0); tick();
        write(2, 4'h1, 32'h5); claimEn = 1; claimSel = 2; step();
        idle();
        settle(); check("claim_wins", b1[1], 1); tick();
        claimEn = 1; claimSel = 4; step();
        claimSel = 6; step();
        settle(); check("pend_4_6", pv[1] & 8'h50, 8'h50); tick();
        flush = 1; claimSel = 7; step();
        idle();
        settle(); check("flush_pvec", pv[1], 0); tick();

        // random traffic with occasional reset pulses
        for (int i = 0; i < 2000; i++) begin
            wrEn     = ($urandom % 2) == 0;
            wrSel    = SB'($urandom);
            wrMask   = L'($urandom);
            dataIn   = $urandom;
            rSel1    = (($urandom % 3) == 0) ? wrSel : SB'($urandom);
            rSel2    = (($urandom % 4) == 0) ? rSel1 : SB'($urandom);
            claimEn  = ($urandom % 3) == 0;
            claimSel = (($urandom % 4) == 0) ? wrSel : SB'($urandom);
            flush    = ($urandom % 20) == 0;
            if (($urandom % 150) == 0) reset_pulse();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
